// File: rtl/move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : move_sequencer (with move_sequencer_pkg)                   |
// | Description : Upstream feeder for move_executor. Buffers incoming moves  |
// |               in a FIFO and issues them one at a time with the current   |
// |               board. It commits each returned board and counts moves and |
// |               captures. It stops on a king capture or executor timeout.  |
// | Ports       : clk_in/rst_in (async active-low) clock and reset           |
// |               load_in/start_board_in   load a new game                   |
// |               move_in/move_valid_in/move_ready_out   move stream in      |
// |               exec_*_out / exec_*_in   request/response to executor      |
// |               board_out, moves_done_out, captures_out   game status      |
// |               busy_out, game_over_out, error_out   control status        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package move_sequencer_pkg;
    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        logic [2:0] promo;
    } move_t;

    typedef struct packed {
        logic [63:0][3:0] squares;
        logic             stm;
        logic [1:0]       checkmate;   // non-zero: a king has been captured
        logic [15:0]      ply;
    } board_t;
endpackage

module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_in,
    input  board_t      start_board_in,
    input  move_t       move_in,
    input  logic        move_valid_in,
    output logic        move_ready_out,
    output move_t       exec_move_out,
    output board_t      exec_board_out,
    output logic        exec_valid_out,
    input  board_t      exec_board_in,
    input  logic        exec_captured_in,
    input  logic        exec_valid_in,
    output board_t      board_out,
    output logic [15:0] moves_done_out,
    output logic [5:0]  captures_out,
    output logic        busy_out,
    output logic        game_over_out,
    output logic        error_out
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [5:0]  CAPS_MAX  = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    move_t       move_q,   move_d;
    board_t      board_q,  board_d;
    logic [15:0] moves_q,  moves_d;
    logic [5:0]  caps_q,   caps_d;
    logic [7:0]  timer_q,  timer_d;
    logic        error_q,  error_d;

    move_t       mem_q [DEPTH];

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_timer_inc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_empty = (wr_ptr_q == rd_ptr_q);

    assign move_ready_out = !w_full && (state_q != S_OVER) && !load_in;
    assign w_push         = move_valid_in && move_ready_out;
    // A load flushes the FIFO, so nothing may be popped in the same cycle.
    assign w_pop          = (state_q == S_IDLE) && !w_empty && !load_in;
    assign w_timer_inc    = timer_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        move_d   = move_q;
        board_d  = board_q;
        moves_d  = moves_q;
        caps_d   = caps_q;
        timer_d  = timer_q;
        error_d  = error_q;

        if (load_in) begin
            // Any result still in flight is dropped: state returns to IDLE,
            // and IDLE does not look at exec_valid_in.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            board_d  = start_board_in;
            moves_d  = '0;
            caps_d   = '0;
            timer_d  = '0;
            error_d  = 1'b0;
            state_d  = S_IDLE;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                move_d   = mem_q[rd_ptr_q[AW-1:0]];
            end

            unique case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (exec_valid_in) begin
                        board_d = exec_board_in;
                        moves_d = moves_q + 16'd1;
                        if (exec_captured_in && (caps_q != CAPS_MAX)) begin
                            caps_d = caps_q + 6'd1;
                        end
                        state_d = (exec_board_in.checkmate != 2'b00) ? S_OVER : S_IDLE;
                    end else begin
                        timer_d = w_timer_inc;
                        if (w_timer_inc == TIMEOUT_C) begin
                            error_d = 1'b1;
                            state_d = S_OVER;
                        end
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            move_q   <= '0;
            board_q  <= '0;
            moves_q  <= '0;
            caps_q   <= '0;
            timer_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            move_q   <= move_d;
            board_q  <= board_d;
            moves_q  <= moves_d;
            caps_q   <= caps_d;
            timer_q  <= timer_d;
            error_q  <= error_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= move_in;
        end
    end

    assign exec_valid_out = (state_q == S_ISSUE);
    assign exec_move_out  = move_q;
    assign exec_board_out = board_q;
    assign board_out      = board_q;
    assign moves_done_out = moves_q;
    assign captures_out   = caps_q;
    assign busy_out       = (state_q != S_IDLE) || !w_empty;
    assign game_over_out  = (state_q == S_OVER);
    assign error_out      = error_q;

endmodule
`default_nettype wire
